// File: rtl/s2p_master.sv
// s2p_master: serial-to-parallel link master.
// Drives sld_n/sclk toward the far-side p2s_slave. Samples the returned serial
// stream si and presents each completed frame on po, with a one-cycle po_vld pulse.
// A frame runs on a single start pulse, or back-to-back while auto_en is held.
// Optional build macro S2P_DBNC_EN: po updates only when two consecutive raw
// frames agree.
module s2p_master #(
  parameter int NBIT  = 64,
  parameter int DIV   = 16,
  parameter int LD_W  = 8,
  parameter int GAP_W = 8,
  parameter int INTV  = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            auto_en,
  input  logic            si,
  output logic            sclk,
  output logic            sld_n,
  output logic [NBIT-1:0] po,
  output logic            po_vld,
  output logic            busy
);

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

  localparam int CNT_MAX1 = (LD_W > GAP_W) ? LD_W : GAP_W;
  localparam int CNT_MAX2 = (DIV > INTV) ? DIV : INTV;
  localparam int CNT_MAX  = (CNT_MAX1 > CNT_MAX2) ? CNT_MAX1 : CNT_MAX2;
  localparam int CNT_W    = clogb2(CNT_MAX);
  localparam int BIT_W    = clogb2(NBIT);

  localparam logic [CNT_W-1:0] LD_LAST   = CNT_W'(LD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] INTV_LAST = CNT_W'(INTV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    SHIFT,
    DONE,
    WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [NBIT-1:0]   sr;
  logic              si_meta;
  logic              si_sync;

`ifdef S2P_DBNC_EN
  logic [NBIT-1:0]   prev_raw;
  logic              prev_vld;
`endif

  // Two-flop synchronizer for the asynchronous return data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      si_meta <= 1'b0;
      si_sync <= 1'b0;
    end else begin
      si_meta <= si;
      si_sync <= si_meta;
    end
  end

  // Frame sequencer: load strobe, gap, clocked shift, then publish the frame.
  // NOTE: every register here uses <= so all branches see the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
      sclk    <= 1'b0;
      sld_n   <= 1'b1;
      po      <= '0;
      po_vld  <= 1'b0;
      busy    <= 1'b0;
`ifdef S2P_DBNC_EN
      prev_raw <= '0;
      prev_vld <= 1'b0;
`endif
    end else begin
      po_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (start || auto_en) begin
            state <= LOAD;
            sld_n <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        LOAD: begin
          if (cnt == LD_LAST) begin
            state <= GAP;
            sld_n <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!sclk) begin
              // Rising edge of sclk: the slave's bit has been stable for a while.
              sclk        <= 1'b1;
              sr[bit_idx] <= si_sync;
            end else begin
              sclk <= 1'b0;
              if (bit_idx == BIT_LAST) begin
                state <= DONE;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          busy <= 1'b0;
          cnt  <= '0;
`ifdef S2P_DBNC_EN
          if (prev_vld && (sr == prev_raw)) begin
            po     <= sr;
            po_vld <= 1'b1;
          end
          prev_raw <= sr;
          prev_vld <= 1'b1;
`else
          po     <= sr;
          po_vld <= 1'b1;
`endif
          state <= auto_en ? WAIT : IDLE;
        end

        WAIT: begin
          if (!auto_en) begin
            state <= IDLE;
          end else if (cnt == INTV_LAST) begin
            state <= LOAD;
            sld_n <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_master.sv
// tb_s2p_master: self-checking bench for s2p_master (NBIT=8, DIV=16, LD_W=8,
// GAP_W=8, INTV=100) with a behavioural p2s_slave on the far end of the link.
module tb_s2p_master;

  localparam int NBIT  = 8;
  localparam int DIV   = 16;
  localparam int LD_W  = 8;
  localparam int GAP_W = 8;
  localparam int INTV  = 100;
  localparam int LAT   = LD_W + GAP_W + 2 * DIV * NBIT + 1;  // 273
  localparam int PER   = LAT + INTV;                         // 373

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            auto_en;
  logic            si;
  logic            sclk;
  logic            sld_n;
  logic [NBIT-1:0] po;
  logic            po_vld;
  logic            busy;

  logic [7:0]      pi;

  s2p_master #(
    .NBIT (NBIT),
    .DIV  (DIV),
    .LD_W (LD_W),
    .GAP_W(GAP_W),
    .INTV (INTV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .auto_en(auto_en),
    .si     (si),
    .sclk   (sclk),
    .sld_n  (sld_n),
    .po     (po),
    .po_vld (po_vld),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Far-side slave: loads pi while sld_n is low, presents bit 0 first and
  // advances on each (synchronized) falling edge of sclk.
  logic [2:0] sclk_s = 3'b000;
  logic [1:0] sld_s  = 2'b11;
  logic [7:0] slv_sr = 8'h00;
  always @(posedge clk) begin
    sclk_s <= {sclk_s[1:0], sclk};
    sld_s  <= {sld_s[0], sld_n};
    if (!sld_s[1])                      slv_sr <= pi;
    else if (sclk_s[2] && !sclk_s[1])   slv_sr <= {slv_sr[0], slv_sr[7:1]};
  end
  assign si = slv_sr[0];

  // Passive monitor: records every po_vld and counts link activity.
  int         vld_cyc_q[$];
  logic [7:0] vld_po_q[$];
  int         sld_low_cnt = 0;
  int         rise_cnt    = 0;
  int         sclk_hi_cnt = 0;
  logic       sclk_d      = 1'b0;
  always @(negedge clk) begin
    if (po_vld) begin
      vld_cyc_q.push_back(cyc);
      vld_po_q.push_back(po);
    end
    if (!sld_n)           sld_low_cnt++;
    if (sclk)             sclk_hi_cnt++;
    if (sclk && !sclk_d)  rise_cnt++;
    sclk_d = sclk;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  // Reference model of what po should show: one call per completed frame.
  logic [7:0] m_po       = 8'h00;
  logic [7:0] m_prev     = 8'h00;
  bit         m_has_prev = 1'b0;

  task automatic model_reset();
    m_po       = 8'h00;
    m_prev     = 8'h00;
    m_has_prev = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] raw, output bit upd);
`ifdef S2P_DBNC_EN
    upd = m_has_prev && (raw == m_prev);
    m_prev     = raw;
    m_has_prev = 1'b1;
`else
    upd = 1'b1;
`endif
    if (upd) m_po = raw;
  endtask

  // One start-triggered frame with optional start pulses at cycles 10 and 50.
  task automatic run_frame(input string tag, input logic [7:0] p, input bit inject,
                           input bit exp_vld, input logic [7:0] exp_po);
    int s, q0, l0, r0, h0;
    pi = p;
    q0 = vld_cyc_q.size();
    l0 = sld_low_cnt;
    r0 = rise_cnt;
    h0 = sclk_hi_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    s = cyc;
    for (int k = 1; k <= LAT; k++) begin
      start = inject && (k == 10 || k == 50);
      tick(1);
      if (k == LAT - 1) begin
        check({tag, " busy_before_done"}, 64'(busy), 64'd1);
        check({tag, " vld_early"}, 64'(po_vld), 64'd0);
      end
    end
    start = 1'b0;
    check({tag, " vld_at_latency"}, 64'(po_vld), 64'(exp_vld));
    check({tag, " busy_low"}, 64'(busy), 64'd0);
    check({tag, " po"}, 64'(po), 64'(exp_po));
    tick(3);
    check({tag, " vld_count"}, 64'(vld_cyc_q.size() - q0), 64'(exp_vld));
    check({tag, " sld_low_cycles"}, 64'(sld_low_cnt - l0), 64'(LD_W));
    check({tag, " sclk_rises"}, 64'(rise_cnt - r0), 64'(NBIT));
    check({tag, " sclk_high_cycles"}, 64'(sclk_hi_cnt - h0), 64'(NBIT * DIV));
    check({tag, " po_hold"}, 64'(po), 64'(exp_po));
    if (vld_cyc_q.size() > q0)
      check({tag, " vld_cycle"}, 64'(vld_cyc_q[q0] - s), 64'(LAT));
  endtask

  typedef struct {
    logic [7:0] pi;
    bit         inject;
    bit         exp_vld;
    logic [7:0] exp_po;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit         upd;
    logic [7:0] p;
    logic [7:0] last_p;
    int         s, q0, l0;
    bit         exp_upd[3];
    logic [7:0] exp_val[3];
    int         n_exp;

    rst_n   = 1'b0;
    start   = 1'b0;
    auto_en = 1'b0;
    pi      = 8'hA5;

    // Table of frames applied right after reset.
`ifdef S2P_DBNC_EN
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{8'h11, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'h22, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{8'h11, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{8'h22, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'h22, 1'b0, 1'b1, 8'h22};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 8'h22};
    vecs[7] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
`else
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5};
    vecs[1] = '{8'h11, 1'b0, 1'b1, 8'h11};
    vecs[2] = '{8'h22, 1'b0, 1'b1, 8'h22};
    vecs[3] = '{8'h11, 1'b0, 1'b1, 8'h11};
    vecs[4] = '{8'h22, 1'b0, 1'b1, 8'h22};
    vecs[5] = '{8'h22, 1'b0, 1'b1, 8'h22};
    vecs[6] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
    vecs[7] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
`endif

    // Reset state.
    tick(3);
    check("reset sclk", 64'(sclk), 64'd0);
    check("reset sld_n", 64'(sld_n), 64'd1);
    check("reset po", 64'(po), 64'd0);
    check("reset po_vld", 64'(po_vld), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    model_reset();
    tick(2);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      model_frame(vecs[i].pi, upd);
      run_frame($sformatf("vec%0d", i), vecs[i].pi, vecs[i].inject,
                vecs[i].exp_vld, vecs[i].exp_po);
      tick(2);
    end

    // Randomized frames against the model; repeats exercise frame agreement.
    last_p = vecs[7].pi;
    for (int r = 0; r < 12; r++) begin
      tick($urandom_range(0, 20));
      p = ($urandom_range(0, 1) == 1) ? last_p : 8'($urandom);
      model_frame(p, upd);
      run_frame($sformatf("rand%0d", r), p, 1'($urandom_range(0, 1)), upd, m_po);
      last_p = p;
    end

    // Auto mode with start and auto_en together; auto_en dropped in frame 3's shift.
    tick(5);
    q0 = vld_cyc_q.size();
    l0 = sld_low_cnt;
    pi      = 8'hA5;
    auto_en = 1'b1;
    start   = 1'b1;
    tick(1);
    start = 1'b0;
    s = cyc;
    n_exp = 0;
    for (int f = 0; f < 3; f++) begin
      model_frame((f == 0) ? 8'hA5 : 8'h3C, upd);
      exp_upd[f] = upd;
      exp_val[f] = m_po;
      if (upd) n_exp++;
    end
    tick_to(s + LAT + 1);
    pi = 8'h3C;
    tick_to(s + PER + 50);
    check("auto busy_frame2", 64'(busy), 64'd1);
    tick_to(s + 2 * PER + 100);
    auto_en = 1'b0;
    tick_to(s + 2 * PER + LAT + 2 * INTV + 50);
    check("auto vld_count", 64'(vld_cyc_q.size() - q0), 64'(n_exp));
    check("auto sld_low_cycles", 64'(sld_low_cnt - l0), 64'(3 * LD_W));
    check("auto idle_busy", 64'(busy), 64'd0);
    check("auto idle_sld_n", 64'(sld_n), 64'd1);
    begin
      int j;
      j = q0;
      for (int f = 0; f < 3; f++) begin
        if (exp_upd[f] && j < vld_cyc_q.size()) begin
          check($sformatf("auto f%0d vld_cycle", f), 64'(vld_cyc_q[j] - s),
                64'(f * PER + LAT));
          check($sformatf("auto f%0d po", f), 64'(vld_po_q[j]), 64'(exp_val[f]));
          j++;
        end
      end
    end
    check("auto po_final", 64'(po), 64'(m_po));

    // Reset in the high phase of shift bit 4, then a fresh frame.
    pi    = 8'hA5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    s = cyc;
    tick_to(s + LD_W + GAP_W + 4 * 2 * DIV + DIV + 5);
    check("midrst sclk_high_before", 64'(sclk), 64'd1);
    rst_n = 1'b0;
    tick(1);
    check("midrst sclk", 64'(sclk), 64'd0);
    check("midrst sld_n", 64'(sld_n), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst po", 64'(po), 64'd0);
    rst_n = 1'b1;
    model_reset();
    tick(3);
    check("midrst stays_idle", 64'(busy), 64'd0);
    model_frame(8'hA5, upd);
    run_frame("after_rst", 8'hA5, 1'b0, upd, m_po);
    model_frame(8'hA5, upd);
    run_frame("after_rst2", 8'hA5, 1'b0, upd, m_po);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
